// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester channel arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: arbiter FSM state encoding and grant index constants.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

  localparam logic GRANT0 = 1'b0;
  localparam logic GRANT1 = 1'b1;

endpackage

// File: rtl/mux2_arbiter_if.sv
// Valid/ready beat channel with packet delimiter, used for both requesters and the output.
// Latency: none (wires only).
// Backpressure: beat moves only on a cycle where valid and ready are both high.
// Signals: valid, ready, data[WIDTH], last. master drives valid/data/last; slave drives ready.
interface mux2_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/mux2_w.sv
// WIDTH-bit 2:1 data select built from one mux cell per bit.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: sel (0 -> a, 1 -> b), a/b data inputs, y selected data.
module mux2_w #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y[i] = sel ? b[i] : a[i];
  end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter sharing one output slot between two requesters, with packet lock.
// Latency: 1 cycle input beat -> out_valid; one beat/cycle sustained when out ready stays high.
// Backpressure: both input readies drop while the output slot is full and not being drained.
// Ports: clk, reset_n (async, active-low); in0/in1 requester channels (slave); out channel (master);
//        out_src (requester of the slot beat), sel (registered grant), locked (mid-packet),
//        xfer_count (accepted beats, wraps).
module mux2_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  mux2_arbiter_if.slave    in0,
  mux2_arbiter_if.slave    in1,
  mux2_arbiter_if.master   out,
  output logic             out_src,
  output logic             sel,
  output logic             locked,
  output logic [CNT_W-1:0] xfer_count
);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             last_grant;
  logic             lg_eff;
  logic             grant;
  logic             slot_free;
  logic             xfer0;
  logic             xfer1;
  logic             xfer;
  logic             xfer_src;
  logic             xfer_last;
  logic [WIDTH-1:0] mux_data;
  logic             out_vld;
  logic [WIDTH-1:0] out_dat;
  logic             out_lst;

  assign slot_free = !out_vld || out.ready;

  // Ready follows the registered select only; the lock term is belt-and-braces
  // since sel already sits on the lock owner for the whole packet.
  assign in0.ready = (sel == GRANT0) && slot_free && (state != ST_LOCK1);
  assign in1.ready = (sel == GRANT1) && slot_free && (state != ST_LOCK0);

  assign xfer0     = in0.valid && in0.ready;
  assign xfer1     = in1.valid && in1.ready;
  assign xfer      = xfer0 || xfer1;
  assign xfer_src  = xfer1;
  assign xfer_last = xfer1 ? in1.last : in0.last;

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .a   (in0.data),
    .b   (in1.data),
    .y   (mux_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FREE:  if (xfer && !xfer_last) state_nxt = xfer_src ? ST_LOCK1 : ST_LOCK0;
      ST_LOCK0: if (xfer0 && in0.last) state_nxt = ST_FREE;
      ST_LOCK1: if (xfer1 && in1.last) state_nxt = ST_FREE;
      default:  state_nxt = ST_FREE;
    endcase
  end

  // Grant for the next cycle is decided with this cycle's transfer already
  // folded in, so alternation on ties is beat-by-beat rather than every other beat.
  always_comb begin
    lg_eff = xfer ? xfer_src : last_grant;
    grant  = sel;
    case (state_nxt)
      ST_LOCK0: grant = GRANT0;
      ST_LOCK1: grant = GRANT1;
      default: begin
        if (in0.valid && in1.valid) grant = ~lg_eff;
        else if (in0.valid)         grant = GRANT0;
        else if (in1.valid)         grant = GRANT1;
        else                        grant = sel;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_FREE;
      last_grant <= GRANT1;
      sel        <= GRANT0;
      locked     <= 1'b0;
      out_vld    <= 1'b0;
      out_dat    <= '0;
      out_lst    <= 1'b0;
      out_src    <= 1'b0;
      xfer_count <= '0;
    end else begin
      state  <= state_nxt;
      sel    <= grant;
      locked <= (state_nxt != ST_FREE);
      if (xfer) begin
        out_vld    <= 1'b1;
        out_dat    <= mux_data;
        out_lst    <= xfer_last;
        out_src    <= xfer_src;
        last_grant <= xfer_src;
        xfer_count <= xfer_count + CNT_W'(1);
      end else if (out.ready) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign out.valid = out_vld;
  assign out.data  = out_dat;
  assign out.last  = out_lst;

endmodule
